wb_shared_slave_arbiter: RTL and testbench
==========================================

Name: wb_shared_slave_arbiter

Overview:
Round-robin Wishbone (classic, non-pipelined) arbiter. It shares one Wishbone slave among NUM_REQ requesters inside the Deca SoC. A typical use is the single I2C master core serving the CAP_SENSE, LIGHT, RH_TEMP and PMONITOR sensor buses. A granted requester keeps the slave for its whole cyc. A per-access timeout recovers the bus from a hung slave.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 255, cycles a strobe may wait for ack/err before forced error; 0 disables the timeout

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req_adr  in  NUM_REQ*AW  requester addresses; requester k occupies slice [k*AW +: AW]
i_req_dat  in  NUM_REQ*DW  requester write data
i_req_sel  in  NUM_REQ*DW/8  requester byte selects
i_req_we  in  NUM_REQ  write enables
i_req_cyc  in  NUM_REQ  cycle requests
i_req_stb  in  NUM_REQ  strobes
o_req_rdt  out  DW  read data, broadcast to all requesters
o_req_ack  out  NUM_REQ  per-requester ack
o_req_err  out  NUM_REQ  per-requester err
o_slv_adr  out  AW  slave address
o_slv_dat  out  DW  slave write data
o_slv_sel  out  DW/8  slave byte selects
o_slv_we  out  1  slave write enable
o_slv_cyc  out  1  slave cycle
o_slv_stb  out  1  slave strobe
i_slv_rdt  in  DW  slave read data
i_slv_ack  in  1  slave ack
i_slv_err  in  1  slave err
o_grant  out  NUM_REQ  one-hot current grant (registered)
o_timeout  out  1  one-cycle pulse on forced timeout

Behaviour:
- Reset (asynchronous, i_rst_n=0): state IDLE, o_grant=0, rr pointer=0, timeout counter=0, o_timeout=0. o_slv_cyc, o_slv_stb, o_req_ack and o_req_err are 0 immediately. Reset mid-transfer drops the slave cycle with no ack to anyone.
- FSM states: IDLE, BUSY, FLUSH.
- IDLE:
  - The slave sees cyc=stb=0.
  - If any i_req_cyc is high, the arbiter picks the first requester with cyc high, searching from the rr pointer upward modulo NUM_REQ.
  - It registers the one-hot grant and moves to BUSY.
  - Grant latency: o_slv_cyc rises exactly 1 cycle after the winning cyc is sampled.
- BUSY:
  - o_slv_adr/dat/sel/we/cyc/stb are a combinational mux of the granted requester.
  - o_req_ack[g] = i_slv_ack and o_req_err[g] = i_slv_err for the granted index g. All other ack/err bits are 0.
  - Slave ack/err arriving in any state other than BUSY is discarded.
  - Several stb/ack pairs may occur within one cyc; the grant is held.
  - When granted cyc is sampled low: go to IDLE and set rr pointer = (g+1) mod NUM_REQ.
  - If cyc falls in the same cycle as an ack, the ack is still delivered.
  - Next arbitration is at the earliest the following cycle, so there is one idle cycle between owners.
- Timeout counter (TIMEOUT>0):
  - Clears whenever stb is low, or ack/err is high.
  - Increments otherwise, saturating.
  - On reaching TIMEOUT (with ack/err low), that cycle: o_req_err[g]=1 (a single-cycle err), o_timeout=1, o_slv_stb=0, o_slv_cyc=0. Next state is FLUSH.
- FLUSH:
  - Slave cyc=stb=0; no ack/err to anyone.
  - Wait until granted cyc is low, then go to IDLE and advance the rr pointer as above.
- Non-granted requesters see ack=err=0 and simply wait; there is no starvation.
  - Worst-case wait is (NUM_REQ-1) ownerships plus one idle cycle each.
- Non-mux datapath outputs (o_slv_adr etc.) are don't-care while cyc=0.
  - They are driven from the grant mux (index 0 when the grant is 0) to avoid X.

Decomposition:
- Shared package wb_arb_pkg holds the state encoding (IDLE/BUSY/FLUSH) and a function computing the round-robin first-one from a request vector and pointer.
- One natural sub-module: rr_priority_picker. It is purely combinational: request vector + pointer in, one-hot winner + index out. It is reused by other arbiters.
- Everything else stays in this module.

Test Plan:
- Single requester 1, write adr=0x10 dat=0xA5, slave acks after 3 cycles -> o_slv_cyc rises 1 cycle after cyc; o_req_ack=4'b0010 for exactly 1 cycle; o_grant=4'b0010.
- All four cyc held from reset, each doing one access with ack after 1 cycle -> grant order 0,1,2,3,0, with one IDLE cycle between owners.
- Requester 2 holds cyc across three stb/ack pairs while requester 0 requests -> requester 0 is not granted until requester 2 drops cyc; then grant=4'b0001.
- TIMEOUT=8, slave never acks requester 3 -> after 8 stalled cycles: o_req_err=4'b1000 and o_timeout high for 1 cycle, slave cyc drops. A late slave ack during FLUSH produces no requester ack.
- i_rst_n pulsed low mid-access (asynchronously, between clock edges) -> o_slv_cyc/stb/ack go 0 immediately. After release, requester 0 wins first (pointer=0).
- Ack and requester cyc drop in the same cycle, then requester 1 requests next cycle -> ack delivered; requester 1 granted with 1-cycle latency; rr pointer equals the old grant+1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared arbitration types and the round-robin first-one search.
package wb_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned MAX_IW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

  // Returns {valid, index} of the first set bit at or above ptr, wrapping modulo n.
  function automatic logic [MAX_IW:0] rr_first(input logic [MAX_REQ-1:0] req,
                                                input logic [MAX_IW-1:0]  ptr,
                                                input int unsigned        n);
    logic [MAX_IW:0] res;
    int unsigned     k;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = (32'(ptr) + i) % n;
      if ((i < n) && !res[MAX_IW] && req[MAX_IW'(k)]) res = {1'b1, MAX_IW'(k)};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: request vector and pointer in, one-hot winner and index out.
module rr_priority_picker
  import wb_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_IW-1:0]  ptr_ext;
  logic [MAX_IW:0]    pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    ptr_ext        = MAX_IW'(ptr);
    pick           = rr_first(req_ext, ptr_ext, N);
  end

  assign valid  = pick[MAX_IW];
  assign idx    = IW'(pick[MAX_IW-1:0]);
  assign onehot = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/wb_shared_slave_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one slave among NUM_REQ requesters,
// with a per-strobe timeout that forces an error and flushes a hung access.
module wb_shared_slave_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ*AW-1:0]   i_req_adr,
  input  logic [NUM_REQ*DW-1:0]   i_req_dat,
  input  logic [NUM_REQ*DW/8-1:0] i_req_sel,
  input  logic [NUM_REQ-1:0]      i_req_we,
  input  logic [NUM_REQ-1:0]      i_req_cyc,
  input  logic [NUM_REQ-1:0]      i_req_stb,
  output logic [DW-1:0]           o_req_rdt,
  output logic [NUM_REQ-1:0]      o_req_ack,
  output logic [NUM_REQ-1:0]      o_req_err,
  output logic [AW-1:0]           o_slv_adr,
  output logic [DW-1:0]           o_slv_dat,
  output logic [DW/8-1:0]         o_slv_sel,
  output logic                    o_slv_we,
  output logic                    o_slv_cyc,
  output logic                    o_slv_stb,
  input  logic [DW-1:0]           i_slv_rdt,
  input  logic                    i_slv_ack,
  input  logic                    i_slv_err,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic                    o_timeout
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IW-1:0]      gidx, gidx_nxt, gidx_inc;
  logic [IW-1:0]      ptr, ptr_nxt;
  logic [TW-1:0]      tcnt, tcnt_nxt;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               g_cyc, g_stb, busy, stalled, tmo_hit;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req    (i_req_cyc),
    .ptr    (ptr),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Grant mux (index 0 while idle) and response routing to the owner only.
  always_comb begin
    o_slv_adr = i_req_adr[32'(gidx)*AW +: AW];
    o_slv_dat = i_req_dat[32'(gidx)*DW +: DW];
    o_slv_sel = i_req_sel[32'(gidx)*SW +: SW];
    o_slv_we  = i_req_we[gidx];
    g_cyc     = i_req_cyc[gidx];
    g_stb     = i_req_stb[gidx] & g_cyc;
    busy      = (state == ST_BUSY);
    stalled   = busy & g_stb & ~i_slv_ack & ~i_slv_err;
    tmo_hit   = (TIMEOUT != 0) && stalled && (tcnt == TW'(TIMEOUT));
    o_slv_cyc = busy & g_cyc & ~tmo_hit;
    o_slv_stb = busy & g_stb & ~tmo_hit;
    o_req_ack = busy ? (o_grant & {NUM_REQ{i_slv_ack}}) : '0;
    o_req_err = busy ? (o_grant & {NUM_REQ{i_slv_err | tmo_hit}}) : '0;
    o_req_rdt = i_slv_rdt;
    o_timeout = tmo_hit;
    gidx_inc  = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = o_grant;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    tcnt_nxt  = '0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_onehot;
          gidx_nxt  = pick_idx;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY, ST_FLUSH: begin
        if (!g_cyc) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          gidx_nxt  = '0;
          ptr_nxt   = gidx_inc;
        end else if (tmo_hit) begin
          state_nxt = ST_FLUSH;
        end else if ((TIMEOUT != 0) && stalled) begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      o_grant <= '0;
      gidx    <= '0;
      ptr     <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      o_grant <= grant_nxt;
      gidx    <= gidx_nxt;
      ptr     <= ptr_nxt;
      tcnt    <= tcnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_shared_slave_arbiter.sv
// Bench for wb_shared_slave_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin ownership model.
module tb_wb_shared_slave_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned TIW = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] r_adr [NR];
  logic [DW-1:0] r_dat [NR];
  logic [SW-1:0] r_sel [NR];
  logic [NR-1:0] r_we, r_cyc, r_stb;
  logic [NR*AW-1:0] req_adr;
  logic [NR*DW-1:0] req_dat;
  logic [NR*SW-1:0] req_sel;
  logic [DW-1:0] req_rdt;
  logic [NR-1:0] req_ack, req_err, grant;
  logic [AW-1:0] slv_adr;
  logic [DW-1:0] slv_dat, slv_rdt;
  logic [SW-1:0] slv_sel;
  logic slv_we, slv_cyc, slv_stb, slv_ack, slv_err, timeout;

  int n_chk = 0;
  int n_pass = 0;
  int m_own, m_ptr;
  int pend [NR];
  bit hold [NR], cool [NR], gap [NR];
  int owners [$];

  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign req_adr[k*AW +: AW] = r_adr[k];
    assign req_dat[k*DW +: DW] = r_dat[k];
    assign req_sel[k*SW +: SW] = r_sel[k];
  end

  wb_shared_slave_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_adr(req_adr), .i_req_dat(req_dat), .i_req_sel(req_sel),
    .i_req_we(r_we), .i_req_cyc(r_cyc), .i_req_stb(r_stb),
    .o_req_rdt(req_rdt), .o_req_ack(req_ack), .o_req_err(req_err),
    .o_slv_adr(slv_adr), .o_slv_dat(slv_dat), .o_slv_sel(slv_sel),
    .o_slv_we(slv_we), .o_slv_cyc(slv_cyc), .o_slv_stb(slv_stb),
    .i_slv_rdt(slv_rdt), .i_slv_ack(slv_ack), .i_slv_err(slv_err),
    .o_grant(grant), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NR; k++) begin
      r_adr[k] = '0; r_dat[k] = '0; r_sel[k] = '0;
    end
    r_we = '0; r_cyc = '0; r_stb = '0;
    slv_ack = 1'b0; slv_err = 1'b0; slv_rdt = '0;
  endtask

  function automatic bit bitof(input logic [NR-1:0] v, input int k);
    return v[k[TIW-1:0]];
  endfunction

  function automatic logic [NR-1:0] oh(input int k);
    return (k < 0) ? '0 : (NR'(1) << k);
  endfunction

  // First requester with cyc high, searching upward from p modulo NR.
  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++)
      if (bitof(v, (p + i) % NR)) return (p + i) % NR;
    return -1;
  endfunction

  // Drives pend[] accesses (bursts if hold[]) with a random-latency slave; checks every cycle.
  task automatic serve(input int max_cyc);
    logic [NR-1:0] prev;
    int c, scnt, lat, tot;
    prev = '0; c = 0; scnt = 0; lat = $urandom_range(0, 3);
    owners.delete();
    forever begin
      tick();
      if (m_own >= 0 && !bitof(prev, m_own)) begin
        m_ptr = (m_own + 1) % NR;
        m_own = -1;
      end else if (m_own < 0 && prev != '0) begin
        m_own = rr_pick(prev, m_ptr);
        owners.push_back(m_own);
      end
      chk("grant", 64'(grant), 64'(oh(m_own)));
      tot = 0;
      foreach (pend[k]) tot += pend[k];
      if (tot == 0 && m_own < 0) break;
      if (c >= max_cyc) begin
        chk("serve_bound", 64'(tot + ((m_own >= 0) ? 1 : 0)), 64'd0);
        break;
      end
      c++;
      for (int k = 0; k < NR; k++) begin
        r_cyc[k] = (pend[k] > 0) && !cool[k];
        r_stb[k] = r_cyc[k] && !gap[k];
        cool[k] = 1'b0; gap[k] = 1'b0;
        r_adr[k] = $urandom; r_dat[k] = $urandom;
        r_sel[k] = SW'($urandom); r_we[k] = 1'($urandom);
      end
      slv_ack = 1'b0; slv_rdt = $urandom;
      #1;
      if (slv_stb) begin
        if (scnt >= lat) begin slv_ack = 1'b1; scnt = 0; lat = $urandom_range(0, 3); end
        else scnt++;
      end
      #1;
      chk("slv_cyc", 64'(slv_cyc), 64'((m_own >= 0) ? bitof(r_cyc, m_own) : 1'b0));
      chk("slv_stb", 64'(slv_stb), 64'((m_own >= 0) ? bitof(r_stb, m_own) : 1'b0));
      chk("req_ack", 64'(req_ack), 64'((slv_ack && m_own >= 0) ? oh(m_own) : '0));
      chk("req_err", 64'(req_err), 64'd0);
      chk("req_rdt", 64'(req_rdt), 64'(slv_rdt));
      if (m_own >= 0 && bitof(r_cyc, m_own)) begin
        chk("slv_adr", 64'(slv_adr), 64'(r_adr[m_own]));
        chk("slv_dat", 64'(slv_dat), 64'(r_dat[m_own]));
        chk("slv_sel", 64'(slv_sel), 64'(r_sel[m_own]));
        chk("slv_we", 64'(slv_we), 64'(bitof(r_we, m_own)));
      end
      if (slv_ack && m_own >= 0) begin
        pend[m_own]--;
        if (hold[m_own] && pend[m_own] > 0) gap[m_own] = 1'b1;
        else cool[m_own] = 1'b1;
      end
      prev = r_cyc;
    end
    clear_inputs();
  endtask

  task automatic reset_model();
    m_own = -1; m_ptr = 0;
    for (int k = 0; k < NR; k++) begin
      pend[k] = 0; hold[k] = 1'b0; cool[k] = 1'b0; gap[k] = 1'b0;
    end
  endtask

  initial begin
    clear_inputs();
    reset_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_slv", 64'({slv_cyc, slv_stb}), 64'd0);
    chk("rst_resp", 64'({req_ack, req_err, timeout}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // single write from requester 1, slave acks on the third strobe cycle
    tick();
    r_cyc[1] = 1'b1; r_stb[1] = 1'b1; r_we[1] = 1'b1;
    r_adr[1] = 32'h10; r_dat[1] = 32'hA5; r_sel[1] = 4'hF;
    #1 chk("t1_idle_cyc", 64'(slv_cyc), 64'd0);
    tick(); #1;
    chk("t1_cyc_rise", 64'(slv_cyc), 64'd1);
    chk("t1_grant", 64'(grant), 64'b0010);
    chk("t1_adr", 64'(slv_adr), 64'h10);
    chk("t1_dat", 64'(slv_dat), 64'hA5);
    chk("t1_we_sel", 64'({slv_we, slv_sel}), 64'h1F);
    chk("t1_ack_c1", 64'(req_ack), 64'd0);
    tick(); #1 chk("t1_ack_c2", 64'(req_ack), 64'd0);
    tick(); slv_ack = 1'b1; slv_rdt = 32'h5A5A;
    #1 chk("t1_ack", 64'(req_ack), 64'b0010);
    chk("t1_rdt", 64'(req_rdt), 64'h5A5A);
    tick(); slv_ack = 1'b0; r_cyc[1] = 1'b0; r_stb[1] = 1'b0;
    #1 chk("t1_ack_once", 64'(req_ack), 64'd0);
    tick(); #1 chk("t1_release", 64'(grant), 64'd0);
    m_ptr = 2;

    // requester 2 bursts three accesses while requester 0 waits
    pend[2] = 3; hold[2] = 1'b1; pend[0] = 1;
    serve(200);
    hold[2] = 1'b0;
    chk("t3_owners_n", 64'(owners.size()), 64'd2);
    if (owners.size() == 2) begin
      chk("t3_first", 64'(owners[0]), 64'd2);
      chk("t3_second", 64'(owners[1]), 64'd0);
    end

    // all four requesting from reset, requester 0 twice
    rst_n = 1'b0; #1 rst_n = 1'b1;
    reset_model();
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    serve(200);
    chk("t2_owners_n", 64'(owners.size()), 64'd5);
    if (owners.size() == 5)
      for (int i = 0; i < 5; i++) chk("t2_order", 64'(owners[i]), 64'(i % NR));

    // hung slave on requester 3
    tick(); r_cyc[3] = 1'b1; r_stb[3] = 1'b1; r_adr[3] = 32'h300;
    tick();
    for (int i = 0; i < TMO; i++) begin
      #1 chk("tmo_wait", 64'({timeout, req_err, slv_cyc}), 64'b000001);
      tick();
    end
    #1;
    chk("tmo_err", 64'(req_err), 64'b1000);
    chk("tmo_pulse", 64'(timeout), 64'd1);
    chk("tmo_drop", 64'({slv_cyc, slv_stb}), 64'd0);
    tick(); slv_ack = 1'b1;
    #1 chk("flush_late_ack", 64'({req_ack, req_err, timeout, slv_cyc}), 64'd0);
    tick(); slv_ack = 1'b0; r_cyc[3] = 1'b0; r_stb[3] = 1'b0;
    #1 chk("flush_grant", 64'(grant), 64'b1000);
    tick(); #1 chk("flush_idle", 64'(grant), 64'd0);
    m_ptr = 0;

    // move pointer off zero, then reset mid-access asynchronously
    pend[1] = 1;
    serve(50);
    tick(); r_cyc[2] = 1'b1; r_stb[2] = 1'b1;
    tick(); #1 chk("ar_busy", 64'(slv_cyc), 64'd1);
    slv_ack = 1'b1;
    #1 chk("ar_ack_pre", 64'(req_ack), 64'b0100);
    #1 rst_n = 1'b0;
    #1 chk("ar_slv", 64'({slv_cyc, slv_stb}), 64'd0);
    chk("ar_ack", 64'(req_ack), 64'd0);
    chk("ar_grant", 64'(grant), 64'd0);
    clear_inputs();
    tick(); rst_n = 1'b1;
    reset_model();
    pend[0] = 1; pend[2] = 1;
    serve(100);
    chk("ar_owners_n", 64'(owners.size()), 64'd2);
    if (owners.size() > 0) chk("ar_first", 64'(owners[0]), 64'd0);

    // ack coincides with cyc drop; next owner picked from old grant + 1
    tick(); r_cyc[0] = 1'b1; r_stb[0] = 1'b1;
    tick(); #1 chk("t6_grant0", 64'(grant), 64'b0001);
    tick(); r_cyc[0] = 1'b0; r_stb[0] = 1'b0; slv_ack = 1'b1;
    #1 chk("t6_ack", 64'(req_ack), 64'b0001);
    tick(); slv_ack = 1'b0; r_cyc = 4'b1011; r_stb = 4'b1011;
    #1 chk("t6_idle", 64'({grant, slv_cyc}), 64'd0);
    tick(); #1;
    chk("t6_grant1", 64'(grant), 64'b0010);
    chk("t6_cyc", 64'(slv_cyc), 64'd1);
    clear_inputs();
    tick();
    m_own = -1; m_ptr = 2;

    // randomized traffic
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NR; k++) begin
        pend[k] = $urandom_range(0, 3);
        hold[k] = 1'($urandom_range(0, 1));
      end
      serve(300);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
